stw_test_scheduler: RTL

Sequencer that shares the BISR systolic array between weight-stationary matmul jobs and periodic stop-the-world (STW) self-test. It grants the array to one matmul job at a time and, every `TEST_INTERVAL` cycles or on demand, runs a fixed set of STW test vectors through the array's STW port. It accumulates the per-PE pass/fail results into a fault map for the repair logic. It sits between the matmul FSM / host and `BISR_STW_systolic`.

---
 rtl/stw_sched_pkg.sv | 30 +++
 rtl/stw_vector_rom.sv | 32 +++
 rtl/stw_test_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/stw_sched_pkg.sv
// stw_sched_pkg
// Shared types and constants for the STW test scheduler:
//   stw_sched_state_t - scheduler FSM states
//   NUM_VEC / VEC_IDX_W - number of STW test vectors and index width
//   VEC_ROM          - test vectors as {op1, op2, add, expected}, where
//                      expected = op1 * op2 + add
package stw_sched_pkg;

  localparam int NUM_VEC   = 4;
  localparam int VEC_IDX_W = $clog2(NUM_VEC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JOB,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_CAPTURE,
    ST_REPORT
  } stw_sched_state_t;

  // Field order inside each entry: op1, op2, add, expected.
  localparam int unsigned VEC_ROM [NUM_VEC][4] = '{
    '{4, 3, 0, 12},
    '{7, 5, 2, 37},
    '{1, 1, 1,  2},
    '{0, 9, 5,  5}
  };

endpackage

// File: rtl/stw_vector_rom.sv
// stw_vector_rom
// Combinational STW test-vector ROM.
//   idx      - vector index
//   en       - drive the selected vector; all outputs are zero when low
//   op1/op2/add_op/expected - vector fields, WORD_SIZE bits each
module stw_vector_rom
  import stw_sched_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [VEC_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [WORD_SIZE-1:0] op1,
  output logic [WORD_SIZE-1:0] op2,
  output logic [WORD_SIZE-1:0] add_op,
  output logic [WORD_SIZE-1:0] expected
);

  always_comb begin
    op1      = '0;
    op2      = '0;
    add_op   = '0;
    expected = '0;
    if (en) begin
      op1      = WORD_SIZE'(VEC_ROM[idx][0]);
      op2      = WORD_SIZE'(VEC_ROM[idx][1]);
      add_op   = WORD_SIZE'(VEC_ROM[idx][2]);
      expected = WORD_SIZE'(VEC_ROM[idx][3]);
    end
  end

endmodule

// File: rtl/stw_test_scheduler.sv
// stw_test_scheduler
// Shares the BISR systolic array between matmul jobs and periodic
// stop-the-world self-test, and folds per-PE results into a fault map.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   job_req/job_grant/job_active/job_done - matmul job handshake
//   force_test                - request a test as soon as the array is free
//   stw_test_load_en, stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected,
//   stw_start, stw_complete, stw_result_mat - STW port of the array
//   fault_map, fault_map_valid - last full-test result (1 = healthy PE)
//   fault_detected, test_timeout - sticky error flags, cleared by rst only
//   test_active               - array owned by the self-test
//   tests_run                 - completed full tests, modulo 256
module stw_test_scheduler
  import stw_sched_pkg::*;
#(
  parameter int ROWS          = 3,
  parameter int COLS          = 3,
  parameter int WORD_SIZE     = 16,
  parameter int TEST_INTERVAL = 64,
  parameter int TIMEOUT       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_req,
  output logic                 job_grant,
  output logic                 job_active,
  input  logic                 job_done,
  input  logic                 force_test,
  output logic                 stw_test_load_en,
  output logic [WORD_SIZE-1:0] stw_mult_op1,
  output logic [WORD_SIZE-1:0] stw_mult_op2,
  output logic [WORD_SIZE-1:0] stw_add_op,
  output logic [WORD_SIZE-1:0] stw_expected,
  output logic                 stw_start,
  input  logic                 stw_complete,
  input  logic [ROWS*COLS-1:0] stw_result_mat,
  output logic [ROWS*COLS-1:0] fault_map,
  output logic                 fault_map_valid,
  output logic                 fault_detected,
  output logic                 test_timeout,
  output logic                 test_active,
  output logic [7:0]           tests_run
);

  localparam int CELLS = ROWS * COLS;
  localparam int ICW   = $clog2(TEST_INTERVAL + 1);
  localparam int TCW   = $clog2(TIMEOUT + 1);

  stw_sched_state_t     state_q, state_d;
  logic [ICW-1:0]       icnt_q, icnt_d, icnt_inc;
  logic [TCW-1:0]       tcnt_q, tcnt_d;
  logic [VEC_IDX_W-1:0] idx_q, idx_d;
  logic                 pending_q, pending_d;
  logic [CELLS-1:0]     res_q, res_d;
  logic [CELLS-1:0]     wmap_q, wmap_d;
  logic [CELLS-1:0]     fmap_q, fmap_d;
  logic                 fmv_q, fmv_d;
  logic                 fdet_q, fdet_d;
  logic                 tmo_q, tmo_d;
  logic [7:0]           runs_q, runs_d;
  logic                 counting, interval_hit, test_due, vec_en;

  // Interval counter only advances while the array is not under test and
  // parks at TEST_INTERVAL until the next REPORT clears it.
  assign counting     = (state_q == ST_IDLE) || (state_q == ST_JOB);
  assign icnt_inc     = (icnt_q == ICW'(TEST_INTERVAL)) ? icnt_q : icnt_q + ICW'(1);
  assign interval_hit = counting && (icnt_inc == ICW'(TEST_INTERVAL));
  // A request arriving this cycle is honoured this cycle, so a forced or
  // interval test in IDLE wins over a simultaneous job_req.
  assign test_due     = pending_q || force_test || interval_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      icnt_q    <= '0;
      tcnt_q    <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      res_q     <= '0;
      wmap_q    <= '1;
      fmap_q    <= '1;
      fmv_q     <= 1'b0;
      fdet_q    <= 1'b0;
      tmo_q     <= 1'b0;
      runs_q    <= '0;
    end else begin
      state_q   <= state_d;
      icnt_q    <= icnt_d;
      tcnt_q    <= tcnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      res_q     <= res_d;
      wmap_q    <= wmap_d;
      fmap_q    <= fmap_d;
      fmv_q     <= fmv_d;
      fdet_q    <= fdet_d;
      tmo_q     <= tmo_d;
      runs_q    <= runs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    icnt_d    = icnt_q;
    tcnt_d    = tcnt_q;
    idx_d     = idx_q;
    pending_d = pending_q || force_test;
    res_d     = res_q;
    wmap_d    = wmap_q;
    fmap_d    = fmap_q;
    fmv_d     = 1'b0;
    fdet_d    = fdet_q;
    tmo_d     = tmo_q;
    runs_d    = runs_q;
    job_grant = 1'b0;

    case (state_q)
      ST_IDLE: begin
        icnt_d = icnt_inc;
        if (interval_hit) pending_d = 1'b1;
        if (test_due) begin
          state_d   = ST_LOAD;
          idx_d     = '0;
          pending_d = 1'b0;
        end else if (job_req) begin
          state_d   = ST_JOB;
          job_grant = 1'b1;
        end
      end
      ST_JOB: begin
        // Tests are only recorded here; a job is never preempted.
        icnt_d = icnt_inc;
        if (interval_hit) pending_d = 1'b1;
        if (job_done) state_d = ST_IDLE;
      end
      ST_LOAD:  state_d = ST_START;
      ST_START: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tcnt_d = tcnt_q + TCW'(1);
        if (stw_complete) begin
          res_d   = stw_result_mat;
          state_d = ST_CAPTURE;
        end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
          // A silent array marks every PE of this vector as failed.
          res_d   = '0;
          tmo_d   = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        wmap_d = wmap_q & res_q;
        if (idx_q == VEC_IDX_W'(NUM_VEC - 1)) begin
          state_d = ST_REPORT;
        end else begin
          idx_d   = idx_q + VEC_IDX_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_REPORT: begin
        fmap_d  = wmap_q;
        fmv_d   = 1'b1;
        fdet_d  = fdet_q || (wmap_q != '1);
        runs_d  = runs_q + 8'd1;
        wmap_d  = '1;
        icnt_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign vec_en = (state_q == ST_LOAD) || (state_q == ST_START) || (state_q == ST_WAIT);

  stw_vector_rom #(.WORD_SIZE(WORD_SIZE)) u_rom (
    .idx      (idx_q),
    .en       (vec_en),
    .op1      (stw_mult_op1),
    .op2      (stw_mult_op2),
    .add_op   (stw_add_op),
    .expected (stw_expected)
  );

  assign job_active       = (state_q == ST_JOB);
  assign stw_test_load_en = (state_q == ST_LOAD);
  assign stw_start        = (state_q == ST_START);
  assign test_active      = !((state_q == ST_IDLE) || (state_q == ST_JOB));
  // Valid is registered so the pulse lines up with the updated fault_map.
  assign fault_map        = fmap_q;
  assign fault_map_valid  = fmv_q;
  assign fault_detected   = fdet_q;
  assign test_timeout     = tmo_q;
  assign tests_run        = runs_q;

endmodule
